// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_pkg
//  Purpose : Shared types for the ALU command sequencer. Defines the ALU
//            opcode set, the sequencer FSM states and the buffered command
//            record.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    SLL = 3'b010,
    LSR = 3'b011,
    AND = 3'b100,
    OR  = 3'b101,
    XOR = 3'b110,
    EQL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } seq_state_e;

  typedef struct packed {
    alu_op_e          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             acc;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : sync_fifo
//  Purpose : Single-clock command FIFO. A write into a full FIFO is ignored
//            even when a read happens in the same cycle (no bypass); a read
//            from an empty FIFO is ignored. Simultaneous write and read
//            leave the occupancy unchanged.
//  Ports   : clk        in   clock, rising edge
//            reset_n    in   asynchronous active-low reset
//            i_push     in   write request
//            i_data     in   write data
//            i_pop      in   read request (head advances)
//            o_data     out  head entry
//            o_full     out  DEPTH entries stored
//            o_empty    out  no entries stored
//  Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One more count state than entries, so full and empty are distinct.
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : alu_cmd_sequencer
//  Purpose : Buffers ALU commands, drives the operand/opcode inputs of a
//            combinational ALU for one full cycle, captures its result and
//            offers it on a valid/ready channel. A command with the acc flag
//            set uses the last captured result as operand A.
//  Ports   : clk, reset_n                 clock / async active-low reset
//            cmd_valid_i, cmd_ready_o     command handshake
//            cmd_op_i, cmd_a_i, cmd_b_i   command opcode and operands
//            cmd_acc_i                    use accumulator as operand A
//            alu_a_o, alu_b_o, alu_op_o   registered ALU inputs
//            alu_res_i                    ALU result
//            res_valid_o, res_ready_i     result handshake
//            res_data_o, res_op_o         captured result and its opcode
//            acc_o                        accumulator
//  Rev     : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [2:0]   cmd_op_i,
  input  logic [W-1:0] cmd_a_i,
  input  logic [W-1:0] cmd_b_i,
  input  logic         cmd_acc_i,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic [2:0]   alu_op_o,
  input  logic [W-1:0] alu_res_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic [W-1:0] res_data_o,
  output logic [2:0]   res_op_o,
  output logic [W-1:0] acc_o
);

  seq_state_e              r_state;
  seq_state_e              w_next_state;
  cmd_t                    w_push_cmd;
  cmd_t                    w_head;
  logic [$bits(cmd_t)-1:0] w_head_bits;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_capture;
  logic                    w_release;

  logic [W-1:0]            r_alu_a;
  logic [W-1:0]            r_alu_b;
  alu_op_e                 r_alu_op;
  logic                    r_res_valid;
  logic [W-1:0]            r_res_data;
  alu_op_e                 r_res_op;
  logic [W-1:0]            r_acc;

  assign w_push_cmd = '{op: alu_op_e'(cmd_op_i), a: cmd_a_i, b: cmd_b_i, acc: cmd_acc_i};
  assign w_head     = cmd_t'(w_head_bits);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (cmd_valid_i),
    .i_data  (w_push_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_ready_o = ~w_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_capture    = 1'b1;
        w_next_state = HOLD;
      end
      HOLD: begin
        if (res_ready_i) begin
          w_release    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand A is resolved at pop time, so a chained command sees the result
  // captured for the command issued just before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= ADD;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= ADD;
      r_acc       <= '0;
    end else begin
      if (w_pop) begin
        r_alu_a  <= w_head.acc ? r_acc : w_head.a;
        r_alu_b  <= w_head.b;
        r_alu_op <= w_head.op;
      end
      if (w_capture) begin
        r_res_data  <= alu_res_i;
        r_acc       <= alu_res_i;
        r_res_op    <= r_alu_op;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_a_o     = r_alu_a;
  assign alu_b_o     = r_alu_b;
  assign alu_op_o    = r_alu_op;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_op_o    = r_res_op;
  assign acc_o       = r_acc;

endmodule
`default_nettype wire
